// File: rtl/uart_tx_if.sv
// Byte-side handshake and serial line of the UART transmitter.
// The controller drives the byte and the start strobe; the transmitter
// reports busy/done and drives the line.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_status;
    logic       tx_done;
    logic       tx;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_status,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_status,
        output tx_done,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 (or 8N2) framing, LSB first.
// Bit timing comes from an internal cycle counter; every output is a flop,
// so the line never glitches and has no combinational path from the inputs.
module uart_tx #(
    parameter int BIT_CYCLES = 10416,
    parameter int STOP_BITS  = 1
) (
    input  logic     sysclk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam logic [15:0] LAST_CYC  = 16'(BIT_CYCLES - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] cyc_r;
    logic [15:0] cyc_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_s;
    logic        tx_r;
    logic        tx_s;
    logic        status_r;
    logic        status_s;
    logic        done_r;
    logic        done_s;
    logic        bit_end_s;
    logic        accept_s;

    // End of the current bit period, and acceptance of a new byte (only when idle).
    assign bit_end_s = (cyc_r == LAST_CYC);
    assign accept_s  = (state_r == S_IDLE) && bus.tx_start;

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: each state lasts a whole number of bit periods.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_s = S_DATA;
                end else begin
                    state_s = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s && (idx_r == 3'd7)) begin
                    state_s = S_STOP;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_STOP: begin
                if (bit_end_s && (idx_r == LAST_STOP)) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_STOP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Datapath: cycle counter, bit/stop index and shift register updates.
    always_comb begin
        cyc_s   = cyc_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        if (accept_s) begin
            cyc_s   = 16'd0;
            idx_s   = 3'd0;
            shift_s = bus.tx_data;
        end else if (state_r != S_IDLE) begin
            if (bit_end_s) begin
                cyc_s = 16'd0;
                case (state_r)
                    S_START: begin
                        idx_s = 3'd0;
                    end
                    S_DATA: begin
                        shift_s = {1'b0, shift_r[7:1]};
                        if (idx_r == 3'd7) begin
                            idx_s = 3'd0;
                        end else begin
                            idx_s = idx_r + 3'd1;
                        end
                    end
                    S_STOP: begin
                        idx_s = idx_r + 3'd1;
                    end
                    default: begin
                        idx_s = 3'd0;
                    end
                endcase
            end else begin
                cyc_s = cyc_r + 16'd1;
            end
        end else begin
            cyc_s = cyc_r;
        end
    end

    // Output logic: next line level, busy flag and completion pulse.
    // The line follows the state being entered so it is ready on the next edge.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            S_IDLE:  tx_s = 1'b1;
            S_START: tx_s = 1'b0;
            S_DATA:  tx_s = shift_s[0];
            S_STOP:  tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
        status_s = (state_s != S_IDLE);
        done_s   = (state_r == S_STOP) && bit_end_s && (idx_r == LAST_STOP);
    end

    // Datapath and output registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cyc_r    <= 16'd0;
            idx_r    <= 3'd0;
            shift_r  <= 8'd0;
            tx_r     <= 1'b1;
            status_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            cyc_r    <= cyc_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            tx_r     <= tx_s;
            status_r <= status_s;
            done_r   <= done_s;
        end
    end

    assign bus.tx        = tx_r;
    assign bus.tx_status = status_r;
    assign bus.tx_done   = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (16 cycles/bit 1 stop,
// 3 cycles/bit 2 stops, default timing). Expected bytes go into a queue when
// driven and are popped when the line delivers the frame.
module tb_uart_tx;

    localparam int BC_A = 16;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic rst_a;
    logic rst_b;
    logic rst_c;

    uart_tx_if if_a ();
    uart_tx_if if_b ();
    uart_tx_if if_c ();

    uart_tx #(.BIT_CYCLES(BC_A), .STOP_BITS(1)) dut_a (.sysclk(sysclk), .reset(rst_a), .bus(if_a));
    uart_tx #(.BIT_CYCLES(3),    .STOP_BITS(2)) dut_b (.sysclk(sysclk), .reset(rst_b), .bus(if_b));
    uart_tx dut_c (.sysclk(sysclk), .reset(rst_c), .bus(if_c));

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    // Records one frame of instance A, first sample at the current negedge.
    task automatic capture_a(input int nbits, output logic [11:0] lv, output int unstable,
                             output int status_low, output int done_seen);
        lv = 12'd0; unstable = 0; status_low = 0; done_seen = 0;
        for (int i = 0; i < nbits * BC_A; i++) begin
            if (i != 0) @(negedge sysclk);
            if ((i % BC_A) == 0) lv[i / BC_A] = if_a.tx;
            else if (if_a.tx !== lv[i / BC_A]) unstable++;
            if (if_a.tx_status !== 1'b1) status_low++;
            if (if_a.tx_done !== 1'b0) done_seen++;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.tx_data = 8'h00; if_a.tx_start = 1'b0;
        if_b.tx_data = 8'h00; if_b.tx_start = 1'b0;
        if_c.tx_data = 8'h00; if_c.tx_start = 1'b0;
        repeat (3) @(negedge sysclk);
        n_checks++; if (if_a.tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b expected 1", if_a.tx); end
        n_checks++; if (if_a.tx_status !== 1'b0) begin n_errors++; $display("FAIL reset_status: got %b expected 0", if_a.tx_status); end
        n_checks++; if (if_a.tx_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", if_a.tx_done); end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            if (if_a.tx !== 1'b1 || if_a.tx_status !== 1'b0 || if_a.tx_done !== 1'b0) bad++;
            if (if_b.tx !== 1'b1 || if_c.tx !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL idle_100: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_single();
        logic [11:0] lv; int unst; int stl; int dn; logic [7:0] e;
        @(negedge sysclk);
        if_a.tx_data = 8'h55; if_a.tx_start = 1'b1; exp_q.push_back(8'h55);
        @(negedge sysclk);
        if_a.tx_start = 1'b0;
        capture_a(10, lv, unst, stl, dn);
        e = exp_q.pop_front();
        n_checks++; if (lv[9:0] !== {1'b1, e, 1'b0}) begin n_errors++; $display("FAIL single_levels: got %b expected %b", lv[9:0], {1'b1, e, 1'b0}); end
        n_checks++; if (unst != 0) begin n_errors++; $display("FAIL single_bit_width: got %0d unstable cycles expected 0", unst); end
        n_checks++; if (stl != 0) begin n_errors++; $display("FAIL single_busy: got %0d non-busy cycles expected 0", stl); end
        n_checks++; if (dn != 0) begin n_errors++; $display("FAIL single_early_done: got %0d expected 0", dn); end
        @(negedge sysclk);
        n_checks++; if ({if_a.tx_done, if_a.tx_status, if_a.tx} !== 3'b101) begin n_errors++; $display("FAIL single_done: got done/status/tx %b expected 101", {if_a.tx_done, if_a.tx_status, if_a.tx}); end
        @(negedge sysclk);
        n_checks++; if (if_a.tx_done !== 1'b0) begin n_errors++; $display("FAIL single_done_width: got %b expected 0", if_a.tx_done); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] lv; int unst; int stl; int dn; logic [7:0] e;
        @(negedge sysclk);
        if_a.tx_data = 8'hA3; if_a.tx_start = 1'b1; exp_q.push_back(8'hA3);
        @(negedge sysclk);
        if_a.tx_data = 8'hFF; exp_q.push_back(8'hFF);
        capture_a(10, lv, unst, stl, dn);
        e = exp_q.pop_front();
        n_checks++; if (lv[9:0] !== {1'b1, e, 1'b0}) begin n_errors++; $display("FAIL b2b_first_levels: got %b expected %b", lv[9:0], {1'b1, e, 1'b0}); end
        n_checks++; if (unst + stl + dn != 0) begin n_errors++; $display("FAIL b2b_first_timing: got %0d/%0d/%0d expected 0/0/0", unst, stl, dn); end
        @(negedge sysclk);
        n_checks++; if ({if_a.tx_done, if_a.tx_status, if_a.tx} !== 3'b101) begin n_errors++; $display("FAIL b2b_done: got done/status/tx %b expected 101", {if_a.tx_done, if_a.tx_status, if_a.tx}); end
        @(negedge sysclk);
        if_a.tx_start = 1'b0;
        capture_a(10, lv, unst, stl, dn);
        e = exp_q.pop_front();
        n_checks++; if (lv[9:0] !== {1'b1, e, 1'b0}) begin n_errors++; $display("FAIL b2b_second_levels: got %b expected %b", lv[9:0], {1'b1, e, 1'b0}); end
        n_checks++; if (unst + stl + dn != 0) begin n_errors++; $display("FAIL b2b_second_timing: got %0d/%0d/%0d expected 0/0/0", unst, stl, dn); end
        @(negedge sysclk);
        n_checks++; if (if_a.tx_done !== 1'b1) begin n_errors++; $display("FAIL b2b_second_done: got %b expected 1", if_a.tx_done); end
    endtask

    task automatic test_reset_abort();
        logic [11:0] lv; int unst; int stl; int dn; int bad; logic [7:0] e;
        @(negedge sysclk);
        if_a.tx_data = 8'h00; if_a.tx_start = 1'b1;
        @(negedge sysclk);
        if_a.tx_start = 1'b0;
        repeat (69) @(negedge sysclk);
        n_checks++; if ({if_a.tx_status, if_a.tx} !== 2'b10) begin n_errors++; $display("FAIL abort_pre: got status/tx %b expected 10", {if_a.tx_status, if_a.tx}); end
        rst_a = 1'b1;
        @(negedge sysclk);
        n_checks++; if ({if_a.tx_done, if_a.tx_status, if_a.tx} !== 3'b001) begin n_errors++; $display("FAIL abort_reset: got done/status/tx %b expected 001", {if_a.tx_done, if_a.tx_status, if_a.tx}); end
        if_a.tx_data = 8'h3C; if_a.tx_start = 1'b1;
        @(negedge sysclk);
        n_checks++; if ({if_a.tx_status, if_a.tx} !== 2'b01) begin n_errors++; $display("FAIL reset_beats_start: got status/tx %b expected 01", {if_a.tx_status, if_a.tx}); end
        rst_a = 1'b0; if_a.tx_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (if_a.tx_done !== 1'b0 || if_a.tx !== 1'b1 || if_a.tx_status !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad); end
        if_a.tx_data = 8'h0F; if_a.tx_start = 1'b1; exp_q.push_back(8'h0F);
        @(negedge sysclk);
        if_a.tx_start = 1'b0;
        capture_a(10, lv, unst, stl, dn);
        e = exp_q.pop_front();
        n_checks++; if (lv[9:0] !== {1'b1, e, 1'b0}) begin n_errors++; $display("FAIL after_abort_levels: got %b expected %b", lv[9:0], {1'b1, e, 1'b0}); end
        n_checks++; if (unst + stl + dn != 0) begin n_errors++; $display("FAIL after_abort_timing: got %0d/%0d/%0d expected 0/0/0", unst, stl, dn); end
        @(negedge sysclk);
        n_checks++; if (if_a.tx_done !== 1'b1) begin n_errors++; $display("FAIL after_abort_done: got %b expected 1", if_a.tx_done); end
    endtask

    task automatic test_two_stop();
        logic [10:0] pat; int bad; int stl; logic [7:0] e;
        @(negedge sysclk);
        if_b.tx_data = 8'h80; if_b.tx_start = 1'b1; exp_q.push_back(8'h80);
        @(negedge sysclk);
        if_b.tx_start = 1'b0;
        e = exp_q.pop_front();
        pat = {2'b11, e, 1'b0};
        bad = 0; stl = 0;
        for (int i = 0; i < 33; i++) begin
            if (i != 0) @(negedge sysclk);
            if (if_b.tx !== pat[i / 3]) bad++;
            if (if_b.tx_status !== 1'b1 || if_b.tx_done !== 1'b0) stl++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL stop2_levels: got %0d wrong cycles expected 0", bad); end
        n_checks++; if (stl != 0) begin n_errors++; $display("FAIL stop2_busy: got %0d bad cycles expected 0", stl); end
        @(negedge sysclk);
        n_checks++; if ({if_b.tx_done, if_b.tx_status, if_b.tx} !== 3'b101) begin n_errors++; $display("FAIL stop2_done_cycle34: got done/status/tx %b expected 101", {if_b.tx_done, if_b.tx_status, if_b.tx}); end
    endtask

    task automatic test_default_width();
        int cnt;
        @(negedge sysclk);
        if_c.tx_data = 8'hFF; if_c.tx_start = 1'b1;
        @(negedge sysclk);
        if_c.tx_start = 1'b0;
        cnt = 0;
        while (if_c.tx === 1'b0 && cnt < 20000) begin
            cnt++;
            @(negedge sysclk);
        end
        n_checks++; if (cnt != 10416) begin n_errors++; $display("FAIL default_start_width: got %0d expected 10416", cnt); end
        n_checks++; if ({if_c.tx_status, if_c.tx} !== 2'b11) begin n_errors++; $display("FAIL default_first_data: got status/tx %b expected 11", {if_c.tx_status, if_c.tx}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_abort();
        test_two_stop();
        test_default_width();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
